// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan serializer.
//   state_e        : serializer FSM states
//   DATA_W, SEL_W  : word width and mux select width (fixed by mux_16x1)
//   start_idx()    : first select index for a given bit order
//   end_idx()      : last select index for a given bit order
package mux_scan_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] start_idx(input bit msb_first);
    return msb_first ? SEL_W'(DATA_W - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] end_idx(input bit msb_first);
    return msb_first ? '0 : SEL_W'(DATA_W - 1);
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// mux_16x1: combinational 16:1 bit multiplexer.
//   in     : 16 candidate bits
//   select : index of the bit to pass through
//   out    : in[select]
module mux_16x1 (
  input  logic [15:0] in,
  input  logic [3:0]  select,
  output logic        out
);

  assign out = in[select];

endmodule

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: loads a 16-bit word over valid/ready and streams it
// out one bit per accepted beat by stepping the select of a mux_16x1.
//   clk, rst_n       : clock, synchronous active-low reset
//   flush            : synchronous abort of the current word
//   in_data/valid/ready : parallel word input handshake
//   ser_bit/valid/ready/last : serial output handshake, last flags final bit
//   sel              : current mux select (debug)
//   busy             : a word is being serialized
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [SEL_W-1:0] START = start_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_I = end_idx(MSB_FIRST);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  // All handshake-facing outputs decode registered state only.
  assign in_ready  = (state_q == IDLE);
  assign ser_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign ser_last  = ser_valid & (sel_q == END_I);
  assign sel       = sel_q;

  mux_16x1 u_mux (
    .in     (data_q),
    .select (sel_q),
    .out    (ser_bit)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (flush) begin
      // data_q is deliberately kept; it is never observed as valid in IDLE.
      state_d = IDLE;
      sel_d   = START;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = in_data;
            sel_d   = START;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (sel_q == END_I) begin
              state_d = IDLE;
              sel_d   = START;
            end else if (MSB_FIRST) begin
              sel_d = sel_q - 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = START;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= START;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

endmodule
